// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage (pre-IF + IF): next-PC generation, instruction SRAM drive,
// and a one-entry hold buffer that keeps {pc, inst} stable under decode back-pressure.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_Allow_in,
  input  logic [33:0] br_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        IF_to_ID_Valid,
  output logic [63:0] IF_to_ID_Bus
);

  logic        br_taken;
  logic [31:0] br_target;
  logic        unused_id_stall;

  assign br_taken        = br_bus[33];
  assign br_target       = br_bus[32:1];
  assign unused_id_stall = br_bus[0];

  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;

  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        if_allow_in;
  logic        to_if_valid;
  logic [31:0] inst;

  assign seq_pc      = if_pc_q + PC_STEP;
  assign nextpc      = br_taken ? br_target : seq_pc;
  assign if_allow_in = ~if_valid_q | ID_Allow_in | br_taken;
  assign to_if_valid = ~reset;

  assign inst_sram_en    = to_if_valid & if_allow_in;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'b0;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    if_pc_d          = if_pc_q;
    if_valid_d       = if_valid_q;
    inst_buf_d       = inst_buf_q;
    inst_buf_valid_d = inst_buf_valid_q;

    if (inst_sram_en) begin
      if_pc_d    = nextpc;
      if_valid_d = 1'b1;
    end

    // A redirect kills the IF instruction, so its held copy must not be replayed.
    if (inst_sram_en || br_taken) begin
      inst_buf_valid_d = 1'b0;
    end else if (if_valid_q && !ID_Allow_in && !inst_buf_valid_q) begin
      inst_buf_d       = inst_sram_rdata;
      inst_buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    if (reset) begin
      if_pc_q          <= RESET_PC - PC_STEP;
      if_valid_q       <= 1'b0;
      inst_buf_q       <= 32'b0;
      inst_buf_valid_q <= 1'b0;
    end else begin
      if_pc_q          <= if_pc_d;
      if_valid_q       <= if_valid_d;
      inst_buf_q       <= inst_buf_d;
      inst_buf_valid_q <= inst_buf_valid_d;
    end
  end

  // SRAM data is only valid the cycle after a read; the buffer covers longer stalls.
  assign inst           = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign IF_to_ID_Valid = if_valid_q & ~reset;
  assign IF_to_ID_Bus   = {if_pc_q, inst};

endmodule

// File: tb/tb_if_stage_fetch.sv
// Scoreboard bench for if_stage_fetch: directed vectors push expected SRAM addresses and
// IF->ID handoffs into queues; a negedge monitor pops and compares on each DUT event.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_Allow_in;
  logic [33:0] br_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'b0;
  logic        IF_to_ID_Valid;
  logic [63:0] IF_to_ID_Bus;

  logic        corrupt = 1'b0;
  int          checks  = 0;
  int          errors  = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_bus_q[$];

  always #5 clk = ~clk;

  if_stage_fetch #(
    .RESET_PC(32'h1c000000),
    .PC_STEP (32'd4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_Allow_in    (ID_Allow_in),
    .br_bus         (br_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .IF_to_ID_Valid (IF_to_ID_Valid),
    .IF_to_ID_Bus   (IF_to_ID_Bus)
  );

  // Synchronous SRAM: mem[a] = a ^ FFFF0000; garbage on the output while idle if corrupt.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ 32'hFFFF0000;
    else if (corrupt) inst_sram_rdata <= 32'hDEADBEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every issued address and every handoff must match the next queued entry.
  always @(negedge clk) begin
    if (inst_sram_en === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL addr_extra: got %h expected none", inst_sram_addr);
      end else begin
        check("sram_addr", {32'b0, inst_sram_addr}, {32'b0, exp_addr_q.pop_front()});
      end
    end
    if (IF_to_ID_Valid === 1'b1 && ID_Allow_in && !br_bus[33]) begin
      if (exp_bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handoff_extra: got %h expected none", IF_to_ID_Bus);
      end else begin
        check("handoff_bus", IF_to_ID_Bus, exp_bus_q.pop_front());
      end
    end
  end

  task automatic drive(input logic rst, input logic allow, input logic taken,
                       input logic [31:0] target);
    @(posedge clk);
    #1;
    reset       = rst;
    ID_Allow_in = allow;
    br_bus      = {taken, target, 1'b0};
  endtask

  initial begin
    reset       = 1'b1;
    ID_Allow_in = 1'b1;
    br_bus      = '0;

    exp_addr_q = '{32'h1c000000, 32'h1c000004, 32'h1c000008, 32'h1c00000c, 32'h1c000010,
                   32'h1c000100, 32'h1c000104, 32'h1c000200, 32'h1c000204, 32'hfffffffc,
                   32'h00000000, 32'h00000004, 32'h1c000000, 32'h1c000004};
    exp_bus_q  = '{{32'h1c000000, 32'he3ff0000}, {32'h1c000004, 32'he3ff0004},
                   {32'h1c000008, 32'he3ff0008}, {32'h1c00000c, 32'he3ff000c},
                   {32'h1c000100, 32'he3ff0100}, {32'h1c000200, 32'he3ff0200},
                   {32'hfffffffc, 32'h0000fffc}, {32'h00000000, 32'hffff0000},
                   {32'h1c000000, 32'he3ff0000}};

    // 1: reset for three cycles, then free-running sequential fetch.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check("reset_valid", {63'b0, IF_to_ID_Valid}, 64'd0);
      check("reset_en", {63'b0, inst_sram_en}, 64'd0);
    end
    check("sram_we", {60'b0, inst_sram_we}, 64'd0);
    check("sram_wdata", {32'b0, inst_sram_wdata}, 64'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 32'h0);

    // 2: five-cycle stall with pc 1c000008 in IF; SRAM output goes bad after cycle one.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      corrupt = 1'b1;
      @(negedge clk);
      check("stall_en", {63'b0, inst_sram_en}, 64'd0);
      check("stall_valid", {63'b0, IF_to_ID_Valid}, 64'd1);
      check("stall_bus", IF_to_ID_Bus, {32'h1c000008, 32'he3ff0008});
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    corrupt = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0);

    // 3: redirect while IF holds 1c000010.
    drive(1'b0, 1'b1, 1'b1, 32'h1c000100);
    drive(1'b0, 1'b1, 1'b0, 32'h0);

    // 4: stall fills the buffer with pc 1c000104, then a redirect arrives mid-stall.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    corrupt = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'h1c000200);
    corrupt = 1'b0;
    @(negedge clk);
    check("redirect_stall_en", {63'b0, inst_sram_en}, 64'd1);
    drive(1'b0, 1'b1, 1'b0, 32'h0);

    // 5: redirect to the top of the address space; the sequential pc wraps to zero.
    drive(1'b0, 1'b1, 1'b1, 32'hfffffffc);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);

    // 6: stall with the buffer full, then reset mid-stall.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("prereset_bus", IF_to_ID_Bus, {32'h00000004, 32'hffff0004});
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("midstall_reset_valid", {63'b0, IF_to_ID_Valid}, 64'd0);
    check("midstall_reset_en", {63'b0, inst_sram_en}, 64'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("postreset_valid", {63'b0, IF_to_ID_Valid}, 64'd0);
    check("postreset_en", {63'b0, inst_sram_en}, 64'd1);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);

    check("addr_queue_drained", 64'(exp_addr_q.size()), 64'd0);
    check("bus_queue_drained", 64'(exp_bus_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
